// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the fetch stage: drives the fetch address and tracks the presented word.
// Optional program-bounds fault is enabled by defining FETCH_LIMIT_EN.
module fetch_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int PROG_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [WORD_WIDTH-1:0] pointer,
    output logic                  instr_valid,
    output logic [WORD_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  jump_valid,
    input  logic [WORD_WIDTH-1:0] jump_target,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  fault
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_pc;
    logic [WORD_WIDTH-1:0] r_resume;
    logic                  r_halted;
    logic                  r_fault;

    logic [WORD_WIDTH-1:0] w_pointer;
    logic                  w_oob;

    always_comb begin
        w_pointer = RESET_VECTOR;
        case (r_state)
            S_RUN: begin
                if (jump_valid)
                    w_pointer = jump_target;
                else if (r_valid && !instr_ready)
                    w_pointer = r_pc;
                else
                    w_pointer = r_pc + 1'b1;
            end
            S_HALT: begin
                if (!halt_req && jump_valid)
                    w_pointer = jump_target;
                else
                    w_pointer = r_resume;
            end
            default: w_pointer = RESET_VECTOR;
        endcase
    end

`ifdef FETCH_LIMIT_EN
    localparam logic [WORD_WIDTH:0] LP_LIMIT = (WORD_WIDTH+1)'(PROG_WORDS);
    assign w_oob = ({1'b0, w_pointer} >= LP_LIMIT);
`else
    assign w_oob = 1'b0;
`endif

    // Bounds are checked only when a word is actually issued (RUN without halt, or resume).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_BOOT;
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_resume <= RESET_VECTOR;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    r_valid <= 1'b1;
                    r_pc    <= RESET_VECTOR;
                end
                S_RUN: begin
                    if (halt_req) begin
                        r_resume <= w_pointer;
                        r_state  <= S_HALT;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_oob) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_valid <= 1'b0;
                    end else begin
                        r_pc    <= w_pointer;
                        r_valid <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (halt_req) begin
                        if (jump_valid)
                            r_resume <= jump_target;
                    end else if (w_oob) begin
                        r_state  <= S_FAULT;
                        r_fault  <= 1'b1;
                        r_halted <= 1'b0;
                    end else begin
                        r_state  <= S_RUN;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pointer;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pointer     = w_pointer;
    assign instr_valid = r_valid;
    assign instr_pc    = r_pc;
    assign halted      = r_halted;
    assign fault       = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and random checks of fetch_ctrl against a behavioural fetch model plus a fetch memory.
module tb_fetch_ctrl;
    localparam int W = 8;
    localparam logic [W-1:0] RV = '0;
`ifdef FETCH_LIMIT_EN
    localparam int PW = 16;
`else
    localparam int PW = 256;
`endif

    logic         clk = 1'b0;
    logic         reset, instr_ready, jump_valid, halt_req;
    logic [W-1:0] jump_target;
    logic [W-1:0] pointer, instr_pc;
    logic         instr_valid, halted, fault;

    always #5 clk = ~clk;

    fetch_ctrl #(.WORD_WIDTH(W), .RESET_VECTOR(RV), .PROG_WORDS(PW)) dut (
        .clk(clk), .reset(reset), .pointer(pointer), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .jump_valid(jump_valid),
        .jump_target(jump_target), .halt_req(halt_req), .halted(halted), .fault(fault)
    );

    // Stand-in for instr_fetch: combinational read registered on the same edge.
    logic [W-1:0] mem [256];
    logic [W-1:0] instr;
    always @(posedge clk) instr <= mem[pointer];

    int total = 0;
    int bad   = 0;

    bit           m_known = 0;
    bit           m_boot, m_halt, m_fault, m_valid;
    logic [W-1:0] m_pc, m_resume;

    function automatic logic [W-1:0] exp_ptr(bit jv, logic [W-1:0] jt, bit hr, bit rdy);
        if (m_boot || m_fault) return RV;
        if (m_halt) return (!hr && jv) ? jt : m_resume;
        if (jv) return jt;
        if (m_valid && !rdy) return m_pc;
        return W'(int'(m_pc) + 1);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(bit r, bit jv, logic [W-1:0] jt, bit hr, bit rdy);
        logic [W-1:0] ep;
        bit           issue_oob;
        reset = r; jump_valid = jv; jump_target = jt; halt_req = hr; instr_ready = rdy;
        #4;
        ep = exp_ptr(jv, jt, hr, rdy);
        if (m_known) begin
            check("pointer", 32'(pointer), 32'(ep));
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("instr_pc", 32'(instr_pc), 32'(m_pc));
            check("halted", 32'(halted), 32'(m_halt));
            check("fault", 32'(fault), 32'(m_fault));
            if (m_valid) check("instr_data", 32'(instr), 32'(mem[m_pc]));
        end
        @(posedge clk);
        issue_oob = (int'(ep) >= PW);
        if (r) begin
            m_known = 1; m_boot = 1; m_halt = 0; m_fault = 0; m_valid = 0;
            m_pc = '0; m_resume = RV;
        end else if (m_boot) begin
            m_boot = 0; m_valid = 1; m_pc = RV;
        end else if (m_fault) begin
        end else if (m_halt) begin
            if (hr) begin
                if (jv) m_resume = jt;
            end else if (issue_oob) begin
                m_halt = 0; m_fault = 1;
            end else begin
                m_halt = 0; m_valid = 1; m_pc = ep;
            end
        end else if (hr) begin
            m_resume = ep; m_halt = 1; m_valid = 0;
        end else if (issue_oob) begin
            m_fault = 1; m_valid = 0;
        end else begin
            m_valid = 1; m_pc = ep;
        end
        #1;
    endtask

    initial begin
        bit hr_lvl;
        for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
        reset = 1; jump_valid = 0; jump_target = '0; halt_req = 0; instr_ready = 1;

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("reset_valid", 32'(instr_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        check("boot_pc", 32'(instr_pc), 32'd0);
        check("boot_valid", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        check("run_pc5", 32'(instr_pc), 32'd5);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        check("stall_pc", 32'(instr_pc), 32'd5);
        check("stall_ptr", 32'(pointer), 32'd5);
        step(0, 0, 0, 0, 1);
        check("unstall_pc", 32'(instr_pc), 32'd6);
        step(0, 0, 0, 0, 1);
`ifndef FETCH_LIMIT_EN
        step(0, 1, 8'h40, 0, 0);
        check("jump_pc", 32'(instr_pc), 32'h40);
        check("jump_instr", 32'(instr), 32'(mem[8'h40]));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_flag", 32'(halted), 32'd1);
        step(0, 1, 8'h20, 1, 1);
        step(0, 0, 0, 0, 1);
        check("resume_pc", 32'(instr_pc), 32'h20);
        check("resume_halted", 32'(halted), 32'd0);
        step(0, 1, 8'hFF, 0, 1);
        check("top_pc", 32'(instr_pc), 32'hFF);
        step(0, 0, 0, 0, 1);
        check("wrap_pc", 32'(instr_pc), 32'h00);
        check("wrap_fault", 32'(fault), 32'd0);
`else
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 1);
        check("limit_pc15", 32'(instr_pc), 32'd15);
        step(0, 0, 0, 0, 1);
        check("limit_fault", 32'(fault), 32'd1);
        check("limit_valid", 32'(instr_valid), 32'd0);
        check("limit_ptr", 32'(pointer), 32'd0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("reboot_pc", 32'(instr_pc), 32'd0);
        check("reboot_fault", 32'(fault), 32'd0);
`endif

        hr_lvl = 0;
        for (int i = 0; i < 600; i++) begin
            bit           r, jv, rdy;
            logic [W-1:0] jt;
            r   = ($urandom_range(0, 63) == 0);
            jv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            jt  = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, PW - 1));
            if ($urandom_range(0, 9) == 0) hr_lvl = ~hr_lvl;
            step(r, jv, jt, hr_lvl, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter sequencer for the instruction fetch stage. Drives `pointer` into `instr_fetch`, tracks which address the registered `instr` word belongs to, and presents a valid/ready handshake to decode. It also handles jump redirects, halt/resume and an optional program-bounds fault. It sits beside `instr_fetch`; `instr_fetch.instr` is the data that accompanies `instr_valid`/`instr_pc`.

## Interface
Parameters:
- `WORD_WIDTH` — default from `parameters.v` — address/instruction width.
- `RESET_VECTOR` — 0 — first fetch address after reset.
- `PROG_WORDS` — 256 — number of legal program words; used only with `FETCH_LIMIT_EN`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `pointer`  out  WORD_WIDTH  — combinational address to `instr_fetch.pointer`.
- `instr_valid`  out  1  — `instr_fetch.instr` holds a live instruction this cycle.
- `instr_pc`  out  WORD_WIDTH  — address of the word in `instr_fetch.instr`.
- `instr_ready`  in  1  — decode accepts; ignored when `instr_valid`=0.
- `jump_valid`  in  1  — redirect request from execute.
- `jump_target`  in  WORD_WIDTH  — redirect address.
- `halt_req`  in  1  — level; stop issuing while high.
- `halted`  out  1  — registered; 1 in HALT.
- `fault`  out  1  — registered; 1 in FAULT; tied 0 without `FETCH_LIMIT_EN`.

## Operation
- States: BOOT, RUN, HALT, FAULT. `reset` forces BOOT.
- Reset values: `instr_valid`=0, `instr_pc`=0, `halted`=0, `fault`=0, `resume_addr`=RESET_VECTOR. `pointer`=RESET_VECTOR while in BOOT.
- BOOT → RUN unconditionally. On that edge: `instr_valid`<=1, `instr_pc`<=RESET_VECTOR.
- `pointer` in RUN, highest priority first:
  - `jump_valid` → `jump_target`.
  - `instr_valid && !instr_ready` → `instr_pc` (re-read; word stays stable).
  - otherwise → `instr_pc`+1, modulo 2^WORD_WIDTH.
- Every RUN edge (no halt): `instr_pc`<=`pointer`, `instr_valid`<=1.
- Jump flushes the presented word. Decode must not treat it as consumed, even if `instr_ready`=1.
- `halt_req`=1 in RUN: `resume_addr`<=`pointer` (same priority rule); state<=HALT; `instr_valid`<=0.
- HALT, `halt_req`=1:
  - `pointer`=`resume_addr`.
  - `jump_valid` loads `resume_addr`<=`jump_target`.
  - Stay in HALT.
- HALT, `halt_req`=0:
  - `pointer`=`jump_valid` ? `jump_target` : `resume_addr`.
  - → RUN with `instr_valid`<=1, `instr_pc`<=`pointer`.
- Priority: `reset` > `jump_valid` > `halt_req` > advance/stall.

## Timing
- Memory read is combinational. `instr_fetch` and this block register on the same edge, so `instr`, `instr_valid` and `instr_pc` are cycle-aligned.
- Reset release to first valid word: 1 cycle (the BOOT cycle).
- Jump latency: target word valid the cycle after `jump_valid`; zero bubbles.
- Throughput: 1 instruction/cycle with `instr_ready` held high.
- Stall: `instr`/`instr_pc` stay constant as long as `instr_ready`=0.
- Halt: `instr_valid` drops the cycle after `halt_req` rises. Resume: `instr_valid`=1 the cycle after `halt_req` falls.
- Reset mid-stall, mid-halt or in FAULT: BOOT on the next edge; all in-flight state is discarded.

## Configuration
`FETCH_LIMIT_EN` defined:
- In RUN or on resume, if the selected `pointer` ≥ PROG_WORDS: state<=FAULT, `fault`<=1, `instr_valid`<=0.
- In FAULT, `pointer`=RESET_VECTOR and the block ignores `jump_valid` and `halt_req`.
- Only `reset` exits FAULT.
- A jump to an out-of-range target also faults.

`FETCH_LIMIT_EN` undefined:
- No FAULT state; `fault`=0.
- `pointer` wraps from 2^WORD_WIDTH−1 to 0.

## Test plan
- Reset, RESET_VECTOR=0, `instr_ready`=1 → `instr_pc` = 0,1,2,3 on consecutive cycles, `instr_valid`=1 from the cycle after reset release.
- `instr_ready`=0 for 3 cycles at `instr_pc`=5 → `pointer`=5, `instr`/`instr_pc` constant; `instr_ready`=1 → `instr_pc`=6 next cycle.
- `jump_valid`=1, `jump_target`=0x40 while `instr_pc`=7, `instr_ready`=0 → next cycle `instr_pc`=0x40, `instr`=mem[0x40].
- `halt_req` high 4 cycles at `instr_pc`=9, accepted → `instr_valid`=0, `halted`=1. Jump to 0x20 while halted, release → `instr_pc`=0x20.
- With `FETCH_LIMIT_EN`, PROG_WORDS=16, run to `instr_pc`=15 accepted → `fault`=1, `instr_valid`=0, `pointer`=0. `reset` → normal boot.
- Without the macro, `jump_target`=2^WORD_WIDTH−1, accept → `instr_pc` wraps to 0, `fault`=0.
